apb_master_bridge: RTL and testbench

APB requester stage that sits directly upstream of the APB bus interface: it accepts single read/write commands on a valid/ready port and drives the APB SETUP/ACCESS sequence onto the bus. It returns the read data and error status on a valid/ready response port. One transfer is outstanding at a time, and a programmable wait-state timeout guards against a slave that never asserts pready.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_wait_timer.sv | 39 +++
 rtl/apb_master_bridge.sv | 122 ++++++++++++
 tb/tb_apb_master_bridge.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default widths for the APB requester bridge.
`default_nettype none

package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  // rdata is sized to the package default; narrower buses zero-extend into it.
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating wait-state counter; expired flags the last allowed ACCESS cycle.
`default_nettype none

module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_counter
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] count;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          count <= '0;
        end else if (inc && (count != MAX)) begin
          count <= count + CW'(1);
        end
      end

      // Count equals the number of pready-low cycles already seen in ACCESS.
      assign expired = (count == LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB requester with valid/ready command and response ports.
`default_nettype none

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr,
  output logic              busy
);

  apb_state_t state;
  apb_rsp_t   rsp_q;
  logic       timer_clr;
  logic       timer_inc;
  logic       timer_expired;

  assign timer_inc = (state == ACCESS) && !pready;
  assign timer_clr = (state == RESP) && rsp_ready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (pclk),
    .rst    (preset),
    .clr    (timer_clr),
    .inc    (timer_inc),
    .expired(timer_expired)
  );

  assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            state     <= SETUP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            psel      <= 1'b1;
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_write ? cmd_wdata : '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          // A late pready beats a timeout that would fire in the same cycle.
          if (pready) begin
            state         <= RESP;
            psel          <= 1'b0;
            penable       <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_q.rdata   <= pwrite ? '0 : APB_DATA_W'(prdata);
            rsp_q.err     <= pslverr;
            rsp_q.timeout <= 1'b0;
          end else if (timer_expired) begin
            state         <= RESP;
            psel          <= 1'b0;
            penable       <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed scenarios for the APB requester bridge.
`default_nettype none

module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .busy(busy)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    preset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h0000_0004; cmd_wdata = 32'h1111_2222;
    rsp_ready = 1'b1; pready = 1'b1; prdata = 32'h0; pslverr = 1'b0;
    tick(); tick(); tick();
    tests++;
    if ({cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, busy} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, busy});
    end
    tests++;
    if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
      fails++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h expected all 0", paddr, pwdata, rsp_rdata);
    end
    preset = 1'b0;
    tick();
    tests++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_cycle: cmd_ready=%b psel=%b expected 1 0", cmd_ready, psel);
    end
    tick();
    tests++;
    if (psel !== 1'b1 || busy !== 1'b1 || paddr !== 32'h4) begin
      fails++;
      $display("FAIL reset_accept: psel=%b busy=%b paddr=%h expected 1 1 00000004", psel, busy, paddr);
    end
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_drain: cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_zero_wait_write();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5_0001;
    pready = 1'b1; prdata = 32'h1234_5678; pslverr = 1'b0; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'h0;
    tests++;
    if ({psel, penable, pwrite} !== 3'b101 || paddr !== 32'h10 || pwdata !== 32'hA5A5_0001 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL zw_setup: sel/en/wr=%b paddr=%h pwdata=%h rdy=%b expected 101 00000010 a5a50001 0",
               {psel, penable, pwrite}, paddr, pwdata, cmd_ready);
    end
    tick();
    tests++;
    if ({psel, penable, pwrite} !== 3'b111 || paddr !== 32'h10 || pwdata !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL zw_access: sel/en/wr=%b paddr=%h pwdata=%h expected 111 00000010 a5a50001",
               {psel, penable, pwrite}, paddr, pwdata);
    end
    tick();
    tests++;
    if ({rsp_valid, psel, penable, rsp_err, rsp_timeout} !== 5'b10000 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL zw_resp: v/sel/en/err/to=%b rdata=%h expected 10000 00000000",
               {rsp_valid, psel, penable, rsp_err, rsp_timeout}, rsp_rdata);
    end
    tick();
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL zw_ready_again: cmd_ready=%b rsp_valid=%b expected 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_wait_read();
    int en_cycles = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'hFFFF_FFFF;
    pready = 1'b0; prdata = 32'h5555_5555; pslverr = 1'b0; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tests++;
    if (pwrite !== 1'b0 || pwdata !== 32'h0 || paddr !== 32'h20 || penable !== 1'b0) begin
      fails++;
      $display("FAIL wr_setup: pwrite=%b pwdata=%h paddr=%h penable=%b expected 0 00000000 00000020 0",
               pwrite, pwdata, paddr, penable);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      if (penable === 1'b1 && psel === 1'b1 && pwdata === 32'h0 && paddr === 32'h20) en_cycles++;
      if (i == 3) begin
        pready = 1'b1; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
      end
      tick();
      pready = 1'b0; prdata = 32'h5555_5555; pslverr = 1'b0;
    end
    tests++;
    if (en_cycles !== 4 || penable !== 1'b0) begin
      fails++;
      $display("FAIL wr_wait_cycles: penable cycles=%0d penable_now=%b expected 4 0", en_cycles, penable);
    end
    tests++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || rsp_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL wr_resp: v/err/to=%b rdata=%h expected 110 deadbeef",
               {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    int early_resp = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; cmd_wdata = 32'h0;
    pready = 1'b0; prdata = 32'h7777_7777; pslverr = 1'b0; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (penable !== 1'b1 || rsp_valid !== 1'b0) early_resp++;
      tick();
    end
    tests++;
    if (early_resp !== 0) begin
      fails++;
      $display("FAIL to_access_len: bad ACCESS cycles=%0d expected 0", early_resp);
    end
    tests++;
    if ({rsp_valid, psel, penable, rsp_err, rsp_timeout} !== 5'b10011 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL to_resp: v/sel/en/err/to=%b rdata=%h expected 10011 00000000",
               {rsp_valid, psel, penable, rsp_err, rsp_timeout}, rsp_rdata);
    end
    tick();
    pready = 1'b1;
  endtask

  task automatic test_boundary_and_backpressure();
    int bad = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = 32'h0;
    pready = 1'b0; prdata = 32'hCAFE_F00D; pslverr = 1'b0; rsp_ready = 1'b0;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL bd_start_ready: cmd_ready=%b expected 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) pready = 1'b1;
      tick();
    end
    pready = 1'b0;
    tests++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL bd_ready_wins: v/err/to=%b rdata=%h expected 100 cafef00d",
               {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    cmd_valid = 1'b1; cmd_addr = 32'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 ||
          cmd_ready !== 1'b0 || psel !== 1'b0 || penable !== 1'b0 || paddr !== 32'h40) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL bd_backpressure: unstable cycles=%0d expected 0", bad);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bd_release: cmd_ready=%b rsp_valid=%b busy=%b expected 1 0 0", cmd_ready, rsp_valid, busy);
    end
    pready = 1'b1;
  endtask

  task automatic test_reset_mid_transfer();
    int spurious = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h0000_00AB;
    pready = 1'b0; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tests++;
    if (penable !== 1'b1) begin
      fails++;
      $display("FAIL rm_in_access: penable=%b expected 1", penable);
    end
    preset = 1'b1;
    tick();
    preset = 1'b0; pready = 1'b1;
    tests++;
    if ({psel, penable, rsp_valid, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL rm_released: sel/en/v/busy=%b expected 0000", {psel, penable, rsp_valid, busy});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || psel !== 1'b0) spurious++;
    end
    tests++;
    if (spurious !== 0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL rm_no_resp: spurious=%0d cmd_ready=%b expected 0 1", spurious, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60; prdata = 32'h0BAD_CAFE; pslverr = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tests++;
    if (psel !== 1'b1 || paddr !== 32'h60) begin
      fails++;
      $display("FAIL rm_next_setup: psel=%b paddr=%h expected 1 00000060", psel, paddr);
    end
    tick(); tick();
    tests++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h0BAD_CAFE) begin
      fails++;
      $display("FAIL rm_next_resp: v/err/to=%b rdata=%h expected 100 0badcafe",
               {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_timeout();
    test_boundary_and_backpressure();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
